// File: rtl/line_seq_ctrl.sv
// Line/frame timing sequencer: ACTIVE then HBLANK per row, VBLANK after the last row.
// All outputs are registered; counter timing is consumed directly by the line-buffer SRAM controller.
module line_seq_ctrl #(
  parameter int LINE_W        = 26,
  parameter int HB            = 52,
  parameter int IMG_H         = 12,
  parameter int VB            = 4,
  parameter int ROW_CNT_WIDTH = 4,
  parameter int COL_CNT_WIDTH = 5,
  parameter int HB_CNT_WIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     hsync_out,
  output logic [COL_CNT_WIDTH-1:0] col_cnt,
  output logic [HB_CNT_WIDTH-1:0]  hb_cnt,
  output logic [ROW_CNT_WIDTH-1:0] row_cnt,
  output logic                     busy,
  output logic                     line_done,
  output logic                     frame_done,
  output logic                     start_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_VBLANK = 2'd3;

  localparam logic [COL_CNT_WIDTH-1:0] COL_LAST = COL_CNT_WIDTH'(LINE_W - 1);
  localparam logic [COL_CNT_WIDTH-1:0] COL_ONE  = COL_CNT_WIDTH'(1);
  localparam logic [HB_CNT_WIDTH-1:0]  HB_LAST  = HB_CNT_WIDTH'(HB - 1);
  localparam logic [HB_CNT_WIDTH-1:0]  HB_ONE   = HB_CNT_WIDTH'(1);
  localparam logic [ROW_CNT_WIDTH-1:0] ROW_LAST = ROW_CNT_WIDTH'(IMG_H - 1);
  localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE  = ROW_CNT_WIDTH'(1);
  localparam logic [7:0]               VB_LAST  = 8'(VB - 1);

  localparam bit PARAMS_OK = (LINE_W >= 1) && (LINE_W <= 2**COL_CNT_WIDTH) &&
                             (HB >= 9) && (HB <= 2**HB_CNT_WIDTH) &&
                             (IMG_H >= 1) && (IMG_H <= 2**ROW_CNT_WIDTH) &&
                             (VB >= 1) && (VB <= 255);

  logic [1:0]               state_q, state_d;
  logic [COL_CNT_WIDTH-1:0] col_q, col_d;
  logic [HB_CNT_WIDTH-1:0]  hb_q, hb_d;
  logic [ROW_CNT_WIDTH-1:0] row_q, row_d;
  logic [7:0]               vb_q, vb_d;
  logic                     hsync_q, hsync_d;
  logic                     busy_q, busy_d;
  logic                     line_done_q, line_done_d;
  logic                     frame_done_q, frame_done_d;
  logic                     start_err_q, start_err_d;

  always_comb begin
    state_d      = state_q;
    col_d        = '0;
    hb_d         = '0;
    row_d        = row_q;
    vb_d         = '0;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      row_d   = '0;
    end else begin
      // A start seen outside IDLE is flagged but never disturbs the running frame.
      start_err_d = start && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ACTIVE;
            row_d   = '0;
          end
        end
        ST_ACTIVE: begin
          if (col_q == COL_LAST) state_d = ST_HBLANK;
          else                   col_d   = col_q + COL_ONE;
        end
        ST_HBLANK: begin
          if (hb_q == HB_LAST) begin
            if (row_q < ROW_LAST) begin
              state_d = ST_ACTIVE;
              row_d   = row_q + ROW_ONE;
            end else begin
              state_d = ST_VBLANK;
            end
          end else begin
            hb_d = hb_q + HB_ONE;
          end
        end
        ST_VBLANK: begin
          if (vb_q == VB_LAST) begin
            state_d      = ST_IDLE;
            row_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            vb_d = vb_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    hsync_d     = (state_d == ST_ACTIVE);
    busy_d      = (state_d != ST_IDLE);
    line_done_d = (state_d == ST_HBLANK) && (hb_d == HB_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      hb_q         <= '0;
      row_q        <= '0;
      vb_q         <= '0;
      hsync_q      <= 1'b0;
      busy_q       <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      hb_q         <= hb_d;
      row_q        <= row_d;
      vb_q         <= vb_d;
      hsync_q      <= hsync_d;
      busy_q       <= busy_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign hsync_out  = hsync_q;
  assign col_cnt    = col_q;
  assign hb_cnt     = hb_q;
  assign row_cnt    = row_q;
  assign busy       = busy_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign start_err  = start_err_q;

  params_legal: assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_line_seq_ctrl.sv
// Self-checking bench for line_seq_ctrl: expected outputs are queued as stimulus is driven
// and compared one cycle later against the DUT.
module tb_line_seq_ctrl;

  localparam int LINE_W = 26;
  localparam int HB     = 52;
  localparam int IMG_H  = 12;
  localparam int VB     = 4;
  localparam int ROW_P  = LINE_W + HB;
  localparam int ACT_END = IMG_H * ROW_P;
  localparam int VB_END  = ACT_END + VB;
  localparam int FD_CYC  = VB_END + 1;

  typedef struct packed {
    logic       hsync;
    logic [4:0] col;
    logic [5:0] hb;
    logic [3:0] row;
    logic       busy;
    logic       ld;
    logic       fd;
    logic       se;
  } exp_t;

  typedef struct {
    string name;
    logic  rst_n;
    logic  st;
    logic  ab;
    exp_t  e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       hsync_out;
  logic [4:0] col_cnt;
  logic [5:0] hb_cnt;
  logic [3:0] row_cnt;
  logic       busy;
  logic       line_done;
  logic       frame_done;
  logic       start_err;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ld_cnt;

  line_seq_ctrl #(
    .LINE_W(LINE_W), .HB(HB), .IMG_H(IMG_H), .VB(VB),
    .ROW_CNT_WIDTH(4), .COL_CNT_WIDTH(5), .HB_CNT_WIDTH(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .hsync_out(hsync_out), .col_cnt(col_cnt), .hb_cnt(hb_cnt), .row_cnt(row_cnt),
    .busy(busy), .line_done(line_done), .frame_done(frame_done), .start_err(start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic hs, int col, int hb, int row, logic bz, logic ld, logic fd, logic se);
    exp_t e;
    e.hsync = hs; e.col = 5'(col); e.hb = 6'(hb); e.row = 4'(row);
    e.busy = bz; e.ld = ld; e.fd = fd; e.se = se;
    return e;
  endfunction

  // Expected outputs c cycles after an accepted start (start sampled in cycle 0).
  function automatic exp_t frame_exp(int c);
    int p;
    int r;
    if (c >= 1 && c <= ACT_END) begin
      p = (c - 1) % ROW_P;
      r = (c - 1) / ROW_P;
      if (p < LINE_W) return mk(1'b1, p, 0, r, 1'b1, 1'b0, 1'b0, 1'b0);
      return mk(1'b0, 0, p - LINE_W, r, 1'b1, (p == ROW_P - 1), 1'b0, 1'b0);
    end
    if (c > ACT_END && c <= VB_END) return mk(1'b0, 0, 0, IMG_H - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (c == FD_CYC) return mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    return '0;
  endfunction

  function automatic exp_t dut_out();
    return mk(hsync_out, int'(col_cnt), int'(hb_cnt), int'(row_cnt), busy, line_done, frame_done, start_err);
  endfunction

  task automatic check(input string name, input int cyc);
    exp_t e;
    exp_t a;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: no expected value queued", name, cyc);
    end else begin
      e = q.pop_front();
      a = dut_out();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got hs=%0b col=%0d hb=%0d row=%0d busy=%0b ld=%0b fd=%0b se=%0b required hs=%0b col=%0d hb=%0d row=%0d busy=%0b ld=%0b fd=%0b se=%0b",
                 name, cyc, a.hsync, a.col, a.hb, a.row, a.busy, a.ld, a.fd, a.se,
                 e.hsync, e.col, e.hb, e.row, e.busy, e.ld, e.fd, e.se);
      end
    end
  endtask

  task automatic tick(input logic st, input logic ab, input exp_t e, input string name, input int cyc);
    start = st;
    abort = ab;
    q.push_back(e);
    @(posedge clk);
    #1;
    check(name, cyc);
  endtask

  // Drives one frame from its start cycle; err_at injects a busy start, abort_at an abort.
  task automatic run_frame(input string name, input int err_at, input int abort_at, output int lds);
    exp_t e;
    bit   done;
    lds  = 0;
    done = 1'b0;
    for (int c = 0; c < FD_CYC && !done; c++) begin
      if (c == abort_at) begin
        tick(1'b0, 1'b1, '0, {name, "_abort"}, c + 1);
        done = 1'b1;
      end else begin
        e = frame_exp(c + 1);
        if (err_at >= 0 && c == err_at) e.se = 1'b1;
        tick((c == 0) || (c == err_at), 1'b0, e, name, c + 1);
        if (line_done) lds++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_count(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"rst_start0",   1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1] = '{"rst_start1",   1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{"rst_release",  1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{"start_abort",  1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{"abort_idle",   1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[5] = '{"start_go",     1'b1, 1'b1, 1'b0, mk(1, 0, 0, 0, 1, 0, 0, 0)};
    vecs[6] = '{"start_busy",   1'b1, 1'b1, 1'b0, mk(1, 1, 0, 0, 1, 0, 0, 1)};
    vecs[7] = '{"active_col2",  1'b1, 1'b0, 1'b0, mk(1, 2, 0, 0, 1, 0, 0, 0)};
    vecs[8] = '{"abort_active", 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[9] = '{"post_abort",   1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #2;
    for (int i = 0; i < 10; i++) begin
      rst_n = vecs[i].rst_n;
      tick(vecs[i].st, vecs[i].ab, vecs[i].e, vecs[i].name, i);
    end

    run_frame("frame_a", -1, -1, ld_cnt);
    check_count("frame_a_line_done", ld_cnt, IMG_H);
    // Frame B starts in frame A's frame_done cycle and sees a rejected start at cycle 100.
    run_frame("frame_b", 100, -1, ld_cnt);
    check_count("frame_b_line_done", ld_cnt, IMG_H);
    tick(1'b0, 1'b0, '0, "idle_after_b", 0);

    run_frame("frame_c", -1, 3 * ROW_P + 10 + 1, ld_cnt);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, '0, "idle_after_abort", i);
    run_frame("frame_d", -1, -1, ld_cnt);
    check_count("frame_d_line_done", ld_cnt, IMG_H);
    tick(1'b0, 1'b0, '0, "idle_after_d", 0);

    tick(1'b1, 1'b0, frame_exp(1), "frame_e", 1);
    for (int c = 1; c < 50; c++) tick(1'b0, 1'b0, frame_exp(c + 1), "frame_e", c + 1);
    #3;
    rst_n = 1'b0;
    #1;
    q.push_back('0);
    check("async_reset", 50);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, '0, "idle_after_reset", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
